// File: rtl/controller_pkg.sv
// Types and constants shared across the controller's UART command path.
package controller_pkg;

  localparam int BYTE_BITS = 8;

  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } packer_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous first-word-fall-through FIFO; a push into a full FIFO is accepted
// when a pop happens on the same edge.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  // Head is forced to zero while empty so the output never shows stale data.
  assign dout    = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= din;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_word_packer.sv
// Packs UART bytes into big-endian words and buffers them in a FWFT FIFO.
// Optional inter-byte timeout discard: define UART_WORD_PACKER_TIMEOUT_EN.
//
//   state   | meaning
//   IDLE    | no bytes of the current word held
//   COLLECT | 1 .. WORD_SIZE_BY-1 bytes of the current word held
module uart_word_packer
  import controller_pkg::*;
#(
  parameter int WORD_SIZE_BY   = 4,
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            byte_valid_i,
  input  logic [BYTE_BITS-1:0]            byte_data_i,
  input  logic                            byte_break_i,
  output logic                            word_valid_o,
  input  logic                            word_ready_i,
  output logic [BYTE_BITS*WORD_SIZE_BY-1:0] word_data_o,
  output logic                            overflow_o,
  output logic                            timeout_o
);

  localparam int W     = BYTE_BITS * WORD_SIZE_BY;
  localparam int CNT_W = $clog2(WORD_SIZE_BY);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WORD_SIZE_BY - 1);

  packer_state_t    state;
  logic [CNT_W-1:0] byte_cnt;
  logic [W-1:0]     shreg;
  logic [W-1:0]     shreg_next;
  logic             word_push;
  logic             word_pop;
  logic             fifo_full;
  logic             fifo_empty;

  // A new word starts from a clean register so no stale bytes linger.
  assign shreg_next = (state == IDLE) ? W'(byte_data_i)
                                      : {shreg[W-BYTE_BITS-1:0], byte_data_i};
  assign word_push  = byte_valid_i && !byte_break_i && (byte_cnt == LAST_IDX);
  assign word_pop   = word_valid_o && word_ready_i;
  assign word_valid_o = !fifo_empty;

`ifdef UART_WORD_PACKER_TIMEOUT_EN
  localparam int TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT_CYCLES - 1);

  logic [TMR_W-1:0] idle_cnt;
`else
  // No timer in this build; the partial word waits for completion or break.
  assign timeout_o = (TIMEOUT_CYCLES < 0);
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      byte_cnt   <= '0;
      shreg      <= '0;
      overflow_o <= 1'b0;
`ifdef UART_WORD_PACKER_TIMEOUT_EN
      idle_cnt   <= '0;
      timeout_o  <= 1'b0;
`endif
    end else begin
`ifdef UART_WORD_PACKER_TIMEOUT_EN
      timeout_o <= 1'b0;
`endif
      if (word_push && fifo_full && !word_pop) begin
        overflow_o <= 1'b1;
      end
      if (byte_break_i) begin
        state    <= IDLE;
        byte_cnt <= '0;
        shreg    <= '0;
`ifdef UART_WORD_PACKER_TIMEOUT_EN
        idle_cnt <= '0;
`endif
      end else if (byte_valid_i) begin
        shreg <= shreg_next;
        if (byte_cnt == LAST_IDX) begin
          state    <= IDLE;
          byte_cnt <= '0;
`ifdef UART_WORD_PACKER_TIMEOUT_EN
          idle_cnt <= '0;
`endif
        end else begin
          state    <= COLLECT;
          byte_cnt <= byte_cnt + 1'b1;
`ifdef UART_WORD_PACKER_TIMEOUT_EN
          idle_cnt <= TMR_LOAD;
`endif
        end
      end
`ifdef UART_WORD_PACKER_TIMEOUT_EN
      // Down-counter expires on the idle cycle that finds it at zero.
      else if (state == COLLECT) begin
        if (idle_cnt == '0) begin
          state     <= IDLE;
          byte_cnt  <= '0;
          shreg     <= '0;
          timeout_o <= 1'b1;
        end else begin
          idle_cnt <= idle_cnt - 1'b1;
        end
      end
`endif
    end
  end

  sync_fifo #(
    .WIDTH (W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (word_push),
    .din   (shreg_next),
    .pop   (word_pop),
    .dout  (word_data_o),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

endmodule

// File: tb/tb_uart_word_packer.sv
// Directed bench for uart_word_packer; follows UART_WORD_PACKER_TIMEOUT_EN.
module tb_uart_word_packer;

  localparam int TMO = 20;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        byte_valid_i = 1'b0;
  logic [7:0]  byte_data_i = 8'h00;
  logic        byte_break_i = 1'b0;
  logic        word_valid_o;
  logic        word_ready_i = 1'b0;
  logic [31:0] word_data_o;
  logic        overflow_o;
  logic        timeout_o;

  int n_tests = 0;
  int n_fail  = 0;

  uart_word_packer #(
    .WORD_SIZE_BY   (4),
    .FIFO_DEPTH     (4),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .byte_valid_i (byte_valid_i),
    .byte_data_i  (byte_data_i),
    .byte_break_i (byte_break_i),
    .word_valid_o (word_valid_o),
    .word_ready_i (word_ready_i),
    .word_data_o  (word_data_o),
    .overflow_o   (overflow_o),
    .timeout_o    (timeout_o)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    byte_valid_i = 1'b1;
    byte_data_i  = b;
    step();
    byte_valid_i = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) send_byte(w[8*i +: 8]);
  endtask

  logic [7:0]  stream [16] = '{8'h00, 8'h00, 8'h00, 8'h70, 8'h00, 8'h00, 8'h00, 8'h57,
                                8'h73, 8'h75, 8'h6E, 8'h67, 8'h00, 8'h00, 8'h00, 8'h4C};
  logic [31:0] stream_w [4] = '{32'h00000070, 32'h00000057, 32'h73756E67, 32'h0000004C};
  logic [31:0] ovf_w [5]    = '{32'hA0A1A2A3, 32'hB0B1B2B3, 32'hC0C1C2C3, 32'hD0D1D2D3, 32'hE0E1E2E3};
  logic [31:0] sim_w [5]    = '{32'h10111213, 32'h20212223, 32'h30313233, 32'h40414243, 32'h50515253};

  int pulses;
  int pulse_at;

  initial begin
    #1;
    do_reset();
    check_eq("rst_valid",    {31'd0, word_valid_o}, 32'd0);
    check_eq("rst_data",     word_data_o,           32'd0);
    check_eq("rst_overflow", {31'd0, overflow_o},   32'd0);
    check_eq("rst_timeout",  {31'd0, timeout_o},    32'd0);

    // Continuous stream, consumer always ready.
    word_ready_i = 1'b1;
    for (int i = 0; i < 16; i++) begin
      send_byte(stream[i]);
      if (i == 2) check_eq("stream_partial_valid", {31'd0, word_valid_o}, 32'd0);
      if (i % 4 == 3) begin
        check_eq("stream_valid", {31'd0, word_valid_o}, 32'd1);
        check_eq("stream_data",  word_data_o, stream_w[i/4]);
      end
    end
    step();
    check_eq("stream_drained", {31'd0, word_valid_o}, 32'd0);

    // Backpressure: four words held, fifth dropped.
    word_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) send_word(ovf_w[i]);
    check_eq("full_head",      word_data_o,         ovf_w[0]);
    check_eq("full_no_ovf",    {31'd0, overflow_o}, 32'd0);
    send_word(ovf_w[4]);
    check_eq("ovf_set",        {31'd0, overflow_o}, 32'd1);
    check_eq("ovf_head_stable", word_data_o,        ovf_w[0]);
    word_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check_eq("drain_valid", {31'd0, word_valid_o}, 32'd1);
      check_eq("drain_data",  word_data_o, ovf_w[i]);
      step();
    end
    check_eq("drain_empty",  {31'd0, word_valid_o}, 32'd0);
    check_eq("ovf_sticky",   {31'd0, overflow_o},   32'd1);

    // Break discards AA BB and a byte arriving with the break.
    send_byte(8'hAA);
    send_byte(8'hBB);
    byte_break_i = 1'b1;
    send_byte(8'hCC);
    byte_break_i = 1'b0;
    check_eq("brk_no_word", {31'd0, word_valid_o}, 32'd0);
    send_word(32'h01020304);
    check_eq("brk_word", word_data_o, 32'h01020304);
    step();
    check_eq("brk_single", {31'd0, word_valid_o}, 32'd0);

    // A byte on the would-be expiry cycle keeps the partial word.
    pulses = 0;
    send_byte(8'h33);
    for (int k = 0; k < TMO - 1; k++) begin
      step();
      if (timeout_o) pulses++;
    end
    send_byte(8'h44);
    if (timeout_o) pulses++;
    check_eq("expiry_byte_no_pulse", pulses, 0);
    send_byte(8'h55);
    send_byte(8'h66);
    check_eq("expiry_byte_word", word_data_o, 32'h33445566);
    step();

    // Inter-byte timeout.
    pulses = 0;
    pulse_at = 0;
    send_byte(8'h11);
    send_byte(8'h22);
    for (int k = 1; k <= TMO + 4; k++) begin
      step();
      if (timeout_o) begin
        pulses++;
        pulse_at = k;
      end
    end
`ifdef UART_WORD_PACKER_TIMEOUT_EN
    check_eq("tmo_pulses", pulses,   1);
    check_eq("tmo_cycle",  pulse_at, TMO);
    check_eq("tmo_no_word", {31'd0, word_valid_o}, 32'd0);
    send_word(32'hC0FFEE00);
    check_eq("tmo_next_word", word_data_o, 32'hC0FFEE00);
`else
    check_eq("tmo_pulses", pulses, 0);
    send_byte(8'hC0);
    send_byte(8'hFF);
    check_eq("held_word", word_data_o, 32'h1122C0FF);
`endif
    step();

    // Push on the same cycle as a pop while full.
    do_reset();
    word_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) send_word(sim_w[i]);
    send_byte(8'h50);
    send_byte(8'h51);
    send_byte(8'h52);
    word_ready_i = 1'b1;
    send_byte(8'h53);
    check_eq("sim_no_ovf", {31'd0, overflow_o}, 32'd0);
    for (int i = 1; i < 5; i++) begin
      check_eq("sim_data", word_data_o, sim_w[i]);
      step();
    end
    check_eq("sim_empty", {31'd0, word_valid_o}, 32'd0);

    // Reset mid-word with a word already buffered.
    word_ready_i = 1'b0;
    send_word(32'hDEADBEEF);
    send_byte(8'h99);
    send_byte(8'h98);
    do_reset();
    check_eq("mid_rst_valid", {31'd0, word_valid_o}, 32'd0);
    check_eq("mid_rst_data",  word_data_o,           32'd0);
    check_eq("mid_rst_ovf",   {31'd0, overflow_o},   32'd0);
    check_eq("mid_rst_tmo",   {31'd0, timeout_o},    32'd0);
    send_word(32'h12345678);
    check_eq("post_rst_valid", {31'd0, word_valid_o}, 32'd1);
    check_eq("post_rst_word",  word_data_o, 32'h12345678);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
